// File: rtl/sp_controller.sv
// sp_controller: sequences PUSH/POP/CALL/RET/INT/RTI stack accesses for the
// memory stage. One 16-bit word is moved per cycle. The SP register and the
// data memory are written through this block's ports, and popped values are
// returned to the pipeline. Bounds are checked once, at accept.
module sp_controller #(
    parameter logic [31:0] SP_TOP   = 32'd2047,
    parameter logic [31:0] SP_LIMIT = 32'd0,
    parameter int          FLAG_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    output logic              op_ready,
    input  logic [15:0]       push_data,
    input  logic [31:0]       pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [31:0]       sp_in,
    output logic [31:0]       sp_wdata,
    output logic              sp_we,
    output logic [31:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic [31:0]       pop_data,
    output logic [FLAG_W-1:0] flags_out,
    output logic              done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, A1, A2, A3, ERRS} state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [31:0]       sp_cur;
    logic [15:0]       push_q;
    logic [31:0]       pc_q;
    logic [FLAG_W-1:0] flags_q;
    logic [1:0]        n_q;
    logic              push_dir_q;
    logic [FLAG_W-1:0] flags_tmp;
    logic [15:0]       pc_lo_q;

    // Held copies of the outputs that keep their value between accesses.
    logic [31:0]       addr_q, addr_nxt;
    logic [15:0]       wdata_q, wdata_nxt;
    logic [31:0]       spw_q, spw_nxt;
    logic [31:0]       pop_q, pop_nxt;
    logic [FLAG_W-1:0] flags_out_q, flags_nxt;

    logic [1:0]  n_in, k;
    logic        push_in, illegal, bound_err, access, last;
    logic [31:0] k32;

    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_addr  = addr_nxt;
    assign mem_wdata = wdata_nxt;
    assign sp_wdata  = spw_nxt;
    assign pop_data  = pop_nxt;
    assign flags_out = flags_nxt;
    assign k32       = {30'b0, k};

    // Next-state, access strobes/addresses and accept-time bounds check.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = IDLE;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        sp_we     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        spw_nxt   = spw_q;
        pop_nxt   = pop_q;
        flags_nxt = flags_out_q;
        k         = 2'd0;
        access    = 1'b0;
        last      = 1'b0;
        n_in      = 2'd0;
        push_in   = 1'b0;
        illegal   = 1'b0;

        case (op_code)
            OP_PUSH: begin n_in = 2'd1; push_in = 1'b1; end
            OP_POP:  n_in = 2'd1;
            OP_CALL: begin n_in = 2'd2; push_in = 1'b1; end
            OP_RET:  n_in = 2'd2;
            OP_INT:  begin n_in = 2'd3; push_in = 1'b1; end
            OP_RTI:  n_in = 2'd3;
            default: illegal = 1'b1;
        endcase
        // Compares are rearranged so neither side can wrap for SP near 0 or 2^32.
        bound_err = illegal ||
                    (push_in  && (sp_in < SP_LIMIT + {30'b0, n_in} - 32'd1)) ||
                    (!push_in && (sp_in > SP_TOP - {30'b0, n_in}));

        case (state)
            IDLE: begin
                if (op_valid) state_nxt = bound_err ? ERRS : A1;
                else          state_nxt = IDLE;
            end
            A1:   begin access = 1'b1; k = 2'd0; end
            A2:   begin access = 1'b1; k = 2'd1; end
            A3:   begin access = 1'b1; k = 2'd2; end
            ERRS: begin err = 1'b1; done = 1'b1; state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase

        if (access) begin
            last  = (k == n_q - 2'd1);
            sp_we = 1'b1;
            if (push_dir_q) begin
                mem_we   = 1'b1;
                addr_nxt = sp_cur - k32;
                spw_nxt  = sp_cur - k32 - 32'd1;
                if (op_q == OP_PUSH)  wdata_nxt = push_q;
                else if (k == 2'd0)   wdata_nxt = pc_q[31:16];
                else if (k == 2'd1)   wdata_nxt = pc_q[15:0];
                else                  wdata_nxt = {{(16-FLAG_W){1'b0}}, flags_q};
            end else begin
                mem_re   = 1'b1;
                addr_nxt = sp_cur + k32 + 32'd1;
                spw_nxt  = addr_nxt;
                if (last) begin
                    pop_nxt = (op_q == OP_POP) ? {16'b0, mem_rdata} : {mem_rdata, pc_lo_q};
                    if (op_q == OP_RTI) flags_nxt = flags_tmp;
                end
            end
            if (last) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end else begin
                state_nxt = (state == A1) ? A2 : A3;
            end
        end
    end

    // State register, accept-time latches, intermediate pop words and held outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            sp_cur      <= 32'd0;
            push_q      <= 16'd0;
            pc_q        <= 32'd0;
            flags_q     <= '0;
            n_q         <= 2'd0;
            push_dir_q  <= 1'b0;
            flags_tmp   <= '0;
            pc_lo_q     <= 16'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 16'd0;
            spw_q       <= 32'd0;
            pop_q       <= 32'd0;
            flags_out_q <= '0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            spw_q       <= spw_nxt;
            pop_q       <= pop_nxt;
            flags_out_q <= flags_nxt;
            if (state == IDLE && op_valid) begin
                op_q       <= op_code;
                sp_cur     <= sp_in;
                push_q     <= push_data;
                pc_q       <= pc_in;
                flags_q    <= flags_in;
                n_q        <= n_in;
                push_dir_q <= push_in;
            end
            if (mem_re && !done) begin
                if (op_q == OP_RTI && state == A1) flags_tmp <= mem_rdata[FLAG_W-1:0];
                else                               pc_lo_q   <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sp_controller.sv
// Directed bench for sp_controller with a behavioural data memory.
module tb_sp_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_ready;
    logic [15:0] push_data;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic [31:0] sp_in;
    logic [31:0] sp_wdata;
    logic        sp_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [31:0] pop_data;
    logic [3:0]  flags_out;
    logic        done;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:4095];

    sp_controller #(.SP_TOP(32'd2047), .SP_LIMIT(32'd100), .FLAG_W(4)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .push_data(push_data), .pc_in(pc_in),
        .flags_in(flags_in), .sp_in(sp_in), .sp_wdata(sp_wdata), .sp_we(sp_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .pop_data(pop_data),
        .flags_out(flags_out), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd4096) ? mem[mem_addr[11:0]] : 16'hxxxx;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd4096) mem[mem_addr[11:0]] <= mem_wdata;
    end

    // Present one request at the current negedge; return at the next negedge (first access cycle).
    task automatic issue(input logic [2:0] op, input logic [31:0] sp, input logic [15:0] pd,
                         input logic [31:0] pc, input logic [3:0] fl);
        op_valid  = 1'b1;
        op_code   = op;
        sp_in     = sp;
        push_data = pd;
        pc_in     = pc;
        flags_in  = fl;
        @(negedge clk);
        op_valid  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        op_valid = 1'b0; op_code = 3'd0; push_data = 16'd0; pc_in = 32'd0;
        flags_in = 4'd0; sp_in = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mem_we, mem_re, sp_we, done, err, busy} !== 6'b0) begin n_bad++; $display("FAIL rst_strobes: got %b want 000000", {mem_we, mem_re, sp_we, done, err, busy}); end
        n_cmp++; if ({sp_wdata, mem_addr, pop_data} !== 96'd0) begin n_bad++; $display("FAIL rst_words: got %h want 0", {sp_wdata, mem_addr, pop_data}); end
        n_cmp++; if ({mem_wdata, flags_out} !== 20'd0) begin n_bad++; $display("FAIL rst_wdata_flags: got %h want 0", {mem_wdata, flags_out}); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", op_ready); end
    endtask

    task automatic test_push_pop;
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL push_ready: got %b want 1", op_ready); end
        issue(3'd0, 32'd2047, 16'hBEEF, 32'd0, 4'd0);
        n_cmp++; if ({mem_we, mem_re, sp_we, done, err, busy} !== 6'b101101) begin n_bad++; $display("FAIL push_strobes: got %b want 101101", {mem_we, mem_re, sp_we, done, err, busy}); end
        n_cmp++; if (mem_addr !== 32'd2047) begin n_bad++; $display("FAIL push_addr: got %0d want 2047", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL push_wdata: got %h want beef", mem_wdata); end
        n_cmp++; if (sp_wdata !== 32'd2046) begin n_bad++; $display("FAIL push_sp: got %0d want 2046", sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_we, sp_we, done, busy} !== 4'b0000) begin n_bad++; $display("FAIL push_after: got %b want 0000", {mem_we, sp_we, done, busy}); end
        n_cmp++; if (mem_addr !== 32'd2047) begin n_bad++; $display("FAIL push_addr_hold: got %0d want 2047", mem_addr); end
        n_cmp++; if (mem[2047] !== 16'hBEEF) begin n_bad++; $display("FAIL push_mem: got %h want beef", mem[2047]); end
        issue(3'd1, 32'd2046, 16'h0, 32'd0, 4'd0);
        n_cmp++; if ({mem_we, mem_re, sp_we, done, err} !== 5'b01110) begin n_bad++; $display("FAIL pop_strobes: got %b want 01110", {mem_we, mem_re, sp_we, done, err}); end
        n_cmp++; if (mem_addr !== 32'd2047) begin n_bad++; $display("FAIL pop_addr: got %0d want 2047", mem_addr); end
        n_cmp++; if (pop_data !== 32'h0000BEEF) begin n_bad++; $display("FAIL pop_data: got %h want 0000beef", pop_data); end
        n_cmp++; if (sp_wdata !== 32'd2047) begin n_bad++; $display("FAIL pop_sp: got %0d want 2047", sp_wdata); end
        @(negedge clk);
        n_cmp++; if (pop_data !== 32'h0000BEEF) begin n_bad++; $display("FAIL pop_data_hold: got %h want 0000beef", pop_data); end
    endtask

    task automatic test_call_ret;
        issue(3'd2, 32'd2047, 16'h0, 32'h0001_2345, 4'd0);
        n_cmp++; if ({mem_we, sp_we, done, mem_addr, mem_wdata, sp_wdata} !== {3'b110, 32'd2047, 16'h0001, 32'd2046}) begin n_bad++; $display("FAIL call_a1: got we%b sp%b d%b a%0d w%h s%0d want 1 1 0 2047 0001 2046", mem_we, sp_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_we, sp_we, done, mem_addr, mem_wdata, sp_wdata} !== {3'b111, 32'd2046, 16'h2345, 32'd2045}) begin n_bad++; $display("FAIL call_a2: got we%b sp%b d%b a%0d w%h s%0d want 1 1 1 2046 2345 2045", mem_we, sp_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem[2047], mem[2046]} !== 32'h0001_2345) begin n_bad++; $display("FAIL call_mem: got %h%h want 00012345", mem[2047], mem[2046]); end
        issue(3'd3, 32'd2045, 16'h0, 32'd0, 4'd0);
        n_cmp++; if ({mem_re, sp_we, done, mem_addr, sp_wdata} !== {3'b110, 32'd2046, 32'd2046}) begin n_bad++; $display("FAIL ret_a1: got re%b sp%b d%b a%0d s%0d want 1 1 0 2046 2046", mem_re, sp_we, done, mem_addr, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_re, sp_we, done, mem_addr, sp_wdata} !== {3'b111, 32'd2047, 32'd2047}) begin n_bad++; $display("FAIL ret_a2: got re%b sp%b d%b a%0d s%0d want 1 1 1 2047 2047", mem_re, sp_we, done, mem_addr, sp_wdata); end
        n_cmp++; if (pop_data !== 32'h0001_2345) begin n_bad++; $display("FAIL ret_pc: got %h want 00012345", pop_data); end
        @(negedge clk);
    endtask

    task automatic test_int_rti;
        issue(3'd4, 32'd2047, 16'h0, 32'h0000_0010, 4'b1010);
        n_cmp++; if ({mem_we, done, mem_addr, mem_wdata, sp_wdata} !== {2'b10, 32'd2047, 16'h0000, 32'd2046}) begin n_bad++; $display("FAIL int_a1: got we%b d%b a%0d w%h s%0d want 1 0 2047 0000 2046", mem_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_we, done, mem_addr, mem_wdata, sp_wdata} !== {2'b10, 32'd2046, 16'h0010, 32'd2045}) begin n_bad++; $display("FAIL int_a2: got we%b d%b a%0d w%h s%0d want 1 0 2046 0010 2045", mem_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_we, done, mem_addr, mem_wdata, sp_wdata} !== {2'b11, 32'd2045, 16'h000A, 32'd2044}) begin n_bad++; $display("FAIL int_a3: got we%b d%b a%0d w%h s%0d want 1 1 2045 000a 2044", mem_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        issue(3'd5, 32'd2044, 16'h0, 32'd0, 4'd0);
        n_cmp++; if ({mem_re, done, mem_addr, sp_wdata} !== {2'b10, 32'd2045, 32'd2045}) begin n_bad++; $display("FAIL rti_a1: got re%b d%b a%0d s%0d want 1 0 2045 2045", mem_re, done, mem_addr, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_re, done, mem_addr, sp_wdata} !== {2'b10, 32'd2046, 32'd2046}) begin n_bad++; $display("FAIL rti_a2: got re%b d%b a%0d s%0d want 1 0 2046 2046", mem_re, done, mem_addr, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem_re, done, mem_addr, sp_wdata} !== {2'b11, 32'd2047, 32'd2047}) begin n_bad++; $display("FAIL rti_a3: got re%b d%b a%0d s%0d want 1 1 2047 2047", mem_re, done, mem_addr, sp_wdata); end
        n_cmp++; if ({pop_data, flags_out} !== {32'h0000_0010, 4'b1010}) begin n_bad++; $display("FAIL rti_result: got pc %h flags %b want 00000010 1010", pop_data, flags_out); end
        @(negedge clk);
        n_cmp++; if (flags_out !== 4'b1010) begin n_bad++; $display("FAIL rti_flags_hold: got %b want 1010", flags_out); end
    endtask

    task automatic test_errors;
        logic [2:0]  ops [0:4];
        logic [31:0] sps [0:4];
        ops[0] = 3'd1; sps[0] = 32'd2047;  // POP on empty stack
        ops[1] = 3'd3; sps[1] = 32'd2046;  // RET with one word
        ops[2] = 3'd0; sps[2] = 32'd99;    // PUSH below limit
        ops[3] = 3'd7; sps[3] = 32'd1000;  // illegal
        ops[4] = 3'd2; sps[4] = 32'd100;   // CALL: second word would land at 99
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], sps[i], 16'h1111, 32'h2222_3333, 4'd0);
            n_cmp++; if ({err, done, mem_we, mem_re, sp_we, busy} !== 6'b110001) begin n_bad++; $display("FAIL err_case%0d: got %b want 110001", i, {err, done, mem_we, mem_re, sp_we, busy}); end
            @(negedge clk);
            n_cmp++; if ({err, done, op_ready} !== 3'b001) begin n_bad++; $display("FAIL err_recover%0d: got %b want 001", i, {err, done, op_ready}); end
        end
        // Boundary that must be accepted: PUSH exactly at SP_LIMIT.
        issue(3'd0, 32'd100, 16'h7777, 32'd0, 4'd0);
        n_cmp++; if ({err, mem_we, done, mem_addr, sp_wdata} !== {3'b011, 32'd100, 32'd99}) begin n_bad++; $display("FAIL push_at_limit: got e%b we%b d%b a%0d s%0d want 0 1 1 100 99", err, mem_we, done, mem_addr, sp_wdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_int;
        mem[2045] = 16'h5A5A;
        mem[2046] = 16'h5A5A;
        issue(3'd4, 32'd2047, 16'h0, 32'h1234_5678, 4'b0101);
        n_cmp++; if ({mem_we, mem_addr} !== {1'b1, 32'd2047}) begin n_bad++; $display("FAIL rint_a1: got we%b a%0d want 1 2047", mem_we, mem_addr); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({mem_we, mem_re, sp_we, done, err, busy} !== 6'b0) begin n_bad++; $display("FAIL rint_strobes: got %b want 000000", {mem_we, mem_re, sp_we, done, err, busy}); end
        n_cmp++; if ({mem_addr, sp_wdata, pop_data} !== 96'd0) begin n_bad++; $display("FAIL rint_words: got %h want 0", {mem_addr, sp_wdata, pop_data}); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({op_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL rint_ready: got %b want 10", {op_ready, busy}); end
        n_cmp++; if ({mem[2047], mem[2046], mem[2045]} !== 48'h1234_5A5A_5A5A) begin n_bad++; $display("FAIL rint_mem: got %h %h %h want 1234 5a5a 5a5a", mem[2047], mem[2046], mem[2045]); end
    endtask

    task automatic test_back_to_back;
        int busy_cnt;
        busy_cnt = 0;
        op_valid = 1'b1; op_code = 3'd2; sp_in = 32'd2047; pc_in = 32'hAAAA_5555;
        @(negedge clk);
        // The requester now holds a PUSH while the CALL is in progress.
        op_code = 3'd0; sp_in = 32'd2045; push_data = 16'hC0DE;
        busy_cnt += busy;
        n_cmp++; if ({op_ready, mem_we, mem_addr} !== {2'b01, 32'd2047}) begin n_bad++; $display("FAIL b2b_a1: got rdy%b we%b a%0d want 0 1 2047", op_ready, mem_we, mem_addr); end
        @(negedge clk);
        busy_cnt += busy;
        n_cmp++; if ({op_ready, done, mem_addr} !== {2'b01, 32'd2046}) begin n_bad++; $display("FAIL b2b_a2: got rdy%b d%b a%0d want 0 1 2046", op_ready, done, mem_addr); end
        @(negedge clk);
        busy_cnt += busy;
        n_cmp++; if ({op_ready, mem_we, done} !== 3'b100) begin n_bad++; $display("FAIL b2b_idle: got %b want 100", {op_ready, mem_we, done}); end
        n_cmp++; if (busy_cnt !== 2) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 2", busy_cnt); end
        @(negedge clk);
        op_valid = 1'b0;
        n_cmp++; if ({mem_we, done, mem_addr, mem_wdata, sp_wdata} !== {2'b11, 32'd2045, 16'hC0DE, 32'd2044}) begin n_bad++; $display("FAIL b2b_push: got we%b d%b a%0d w%h s%0d want 1 1 2045 c0de 2044", mem_we, done, mem_addr, mem_wdata, sp_wdata); end
        @(negedge clk);
        n_cmp++; if ({mem[2047], mem[2046], mem[2045]} !== 48'hAAAA_5555_C0DE) begin n_bad++; $display("FAIL b2b_mem: got %h %h %h want aaaa 5555 c0de", mem[2047], mem[2046], mem[2045]); end
    endtask

    initial begin
        test_reset;
        test_push_pop;
        test_call_ret;
        test_int_rti;
        test_errors;
        test_reset_mid_int;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_controller.md
Name: sp_controller

Overview:
- Sequences every stack access for the memory stage: PUSH, POP, CALL, RET, INT, RTI.
- Takes the current stack pointer from the SP register and computes the word addresses for the 16-bit data memory.
- Drives the SP register write port and returns popped data to the pipeline.
- Holds the pipeline busy during multi-word operations and flags stack overflow or underflow.

Parameters:
SP_TOP, 2047, SP value of an empty stack (the SP register reset value)
SP_LIMIT, 0, lowest word address the stack may write
FLAG_W, 4, width of the flags word saved by INT and restored by RTI

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  stack operation request
op_code  in  3  0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6/7 illegal
op_ready  out  1  high in IDLE; request accepted when op_valid && op_ready
push_data  in  16  PUSH operand, sampled at accept
pc_in  in  32  return PC for CALL/INT, sampled at accept
flags_in  in  FLAG_W  flags for INT, sampled at accept
sp_in  in  32  current SP register value, sampled at accept
sp_wdata  out  32  new SP value
sp_we  out  1  SP register write enable
mem_addr  out  32  word address
mem_wdata  out  16  write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rdata  in  16  read data, combinational (valid in the same cycle as mem_re)
pop_data  out  32  POP: {16'b0, word}; RET/RTI: PC
flags_out  out  FLAG_W  flags restored by RTI
done  out  1  one-cycle pulse in the final cycle of an operation
err  out  1  one-cycle pulse on overflow, underflow or illegal op
busy  out  1  state != IDLE

Behaviour:
Stack discipline:
- Descending stack; SP points to the next free word.
- Push word: mem[SP] <= w, then SP <= SP-1.
- Pop word: SP <= SP+1, then w <= mem[SP].

Accept and latency:
- At accept, latch op_code, sp_in (into local sp_cur), push_data, pc_in and flags_in.
- Accesses start the next cycle, one word per cycle.
- Latency from accept to done: PUSH/POP 1 cycle, CALL/RET 2, INT/RTI 3.

States and word order:
- IDLE: the only state with op_ready=1.
- A1, A2, A3: access states.
- ERRS: one-cycle error state.
- CALL: A1 writes PC[31:16] at sp_cur, A2 writes PC[15:0] at sp_cur-1; final SP = sp_cur-2.
- INT: same two writes as CALL, then A3 writes {zero-pad, flags} at sp_cur-2; final SP = sp_cur-3.
- RTI: A1 reads flags from sp_cur+1, A2 reads PC[15:0] from sp_cur+2, A3 reads PC[31:16] from sp_cur+3; final SP = sp_cur+3.
- RET: identical to RTI without the flags read (A1 reads PC[15:0] from sp_cur+1, A2 reads PC[31:16] from sp_cur+2).

Per-access-cycle outputs:
- Each access cycle asserts sp_we=1 with sp_wdata equal to SP after that word, so the SP register stays consistent every cycle.
- Intermediate results (flags, PC low half) are held in internal registers.
- pop_data and flags_out update in the done cycle and hold until the next done.

Bounds, checked at accept with a 32-bit unsigned compare of the latched SP:
- Overflow: the last push address is below SP_LIMIT, i.e. sp_cur - (n-1) < SP_LIMIT, where n is the number of words pushed.
- Underflow: sp_cur + n > SP_TOP, where n is the number of words popped.
- Illegal op_code (6/7) is also an error.
- On any error, go to ERRS: err=1, done=1, no mem_we, mem_re or sp_we; then IDLE.

Outputs between accesses:
- mem_we, mem_re, sp_we, done and err are 0 outside the cases above.
- mem_addr and mem_wdata hold their last values.

Reset (reset=0, asynchronous):
- state=IDLE; all strobes, done and err = 0.
- pop_data=0, flags_out=0, sp_wdata=0, mem_addr=0, mem_wdata=0.
- Any in-flight operation is abandoned with no further writes. A partial push may leave words already written in memory; that is acceptable.

Other boundaries:
- op_valid while busy is ignored (op_ready=0); the requester holds it.
- Back-to-back: a new op can be accepted in the cycle after done, in IDLE.
- Address arithmetic is 32-bit; no wrap is possible because of the bounds checks.

Test Plan:
1. sp_in=2047, PUSH 0xBEEF → T+1: mem_we, addr 2047, wdata 0xBEEF, sp_wdata 2046, done; then POP with sp_in=2046 → mem_re addr 2047, pop_data 0x0000BEEF, sp_wdata 2047.
2. CALL, pc_in=0x0001_2345, sp_in=2047 → writes 0x0001@2047, then 0x2345@2046, SP 2045, done on 2nd cycle; RET from 2045 → pop_data 0x00012345, SP 2047.
3. INT flags=4'b1010, pc=0x10, sp=2047 → writes 0x0000@2047, 0x0010@2046, 0x000A@2045, SP 2044; RTI → flags_out 1010, pop_data 0x10, SP 2047.
4. POP at sp_in=2047, RET at 2046, PUSH at SP_LIMIT-1 (use SP_LIMIT=100, sp=99), op_code 7 → err=1, done=1, no strobes, SP unchanged.
5. reset=0 asserted asynchronously mid-INT after A1 → outputs cleared immediately, no A2/A3 writes, op_ready=1 after release.
6. op_valid held high during CALL → second op accepted only in the cycle after done; busy high exactly 2 cycles.
